// File: rtl/uc_dispara_tiro.sv
// Shot-spawn control unit: scans the shot memory for the first free slot and writes a new shot there.
// Optional post-shot cooldown is enabled by defining UC_DISPARA_TIRO_COOLDOWN_EN.
module uc_dispara_tiro #(
   parameter int N_TIROS         = 8,
   parameter int ADDR_W          = 3,
   parameter int COORD_W         = 8,
   parameter int COOLDOWN_CICLOS = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               disparar,
   input  logic               bloqueio,
   input  logic [COORD_W-1:0] nave_x,
   input  logic [COORD_W-1:0] nave_y,
   input  logic [1:0]         nave_direcao,
   input  logic               mem_loaded_rd,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_we,
   output logic [COORD_W-1:0] wr_x,
   output logic [COORD_W-1:0] wr_y,
   output logic [1:0]         wr_opcode,
   output logic               wr_loaded,
   output logic               disparo_concluido,
   output logic               sem_slot,
   output logic               ocupado,
   output logic [3:0]         db_estado
);

   localparam logic [3:0] INICIO   = 4'd0;
   localparam logic [3:0] ESPERA   = 4'd1;
   localparam logic [3:0] CAPTURA  = 4'd2;
   localparam logic [3:0] LE       = 4'd3;
   localparam logic [3:0] VERIFICA = 4'd4;
   localparam logic [3:0] PROXIMO  = 4'd5;
   localparam logic [3:0] GRAVA    = 4'd6;
   localparam logic [3:0] SINALIZA = 4'd7;
   localparam logic [3:0] CHEIO    = 4'd8;

   localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_TIROS - 1);
   localparam logic [ADDR_W-1:0] UM     = ADDR_W'(1);

   logic [3:0]         estado;
   logic [3:0]         prox;
   logic               pendente;
   logic               aceita;
   logic [ADDR_W-1:0]  addr;
   logic [COORD_W-1:0] lat_x;
   logic [COORD_W-1:0] lat_y;
   logic [1:0]         lat_op;

`ifdef UC_DISPARA_TIRO_COOLDOWN_EN
   localparam int CD_W = $clog2(COOLDOWN_CICLOS + 1);
   localparam logic [CD_W-1:0] CD_CARGA = CD_W'(COOLDOWN_CICLOS);
   localparam logic [CD_W-1:0] CD_ZERO  = {CD_W{1'b0}};
   localparam logic [CD_W-1:0] CD_UM    = CD_W'(1);

   logic [CD_W-1:0] cooldown;

   // Requests are discarded while the post-shot cooldown is still running
   assign aceita = disparar & (cooldown == CD_ZERO);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cooldown <= CD_ZERO;
      else if (estado == SINALIZA)
         cooldown <= CD_CARGA;
      else if (cooldown != CD_ZERO)
         cooldown <= cooldown - CD_UM;
      else
         cooldown <= cooldown;
   end
`else
   assign aceita = disparar;
`endif

   // Next-state logic
   always_comb begin
      prox = INICIO;
      case (estado)
         INICIO:   prox = ESPERA;
         ESPERA:   if (pendente && !bloqueio) prox = CAPTURA; else prox = ESPERA;
         CAPTURA:  prox = LE;
         LE:       prox = VERIFICA;
         VERIFICA: begin
            if (!mem_loaded_rd)     prox = GRAVA;
            else if (addr == ULTIMO) prox = CHEIO;
            else                     prox = PROXIMO;
         end
         PROXIMO:  prox = LE;
         GRAVA:    prox = SINALIZA;
         SINALIZA: prox = ESPERA;
         CHEIO:    prox = ESPERA;
         default:  prox = INICIO;
      endcase
   end

   // State, pending request, slot address and latched shot fields
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado   <= INICIO;
         pendente <= 1'b0;
         addr     <= {ADDR_W{1'b0}};
         lat_x    <= {COORD_W{1'b0}};
         lat_y    <= {COORD_W{1'b0}};
         lat_op   <= 2'b00;
      end else begin
         estado <= prox;
         // A new request wins over the clear so it is never lost
         if (aceita)
            pendente <= 1'b1;
         else if (estado == ESPERA && prox == CAPTURA)
            pendente <= 1'b0;
         else
            pendente <= pendente;
         if (estado == CAPTURA) begin
            addr   <= {ADDR_W{1'b0}};
            lat_x  <= nave_x;
            lat_y  <= nave_y;
            lat_op <= nave_direcao;
         end else if (estado == PROXIMO) begin
            addr <= addr + UM;
         end else begin
            addr <= addr;
         end
      end
   end

   // Moore outputs registered from the next state so they line up with the state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_we            <= 1'b0;
         wr_loaded         <= 1'b0;
         disparo_concluido <= 1'b0;
         sem_slot          <= 1'b0;
         ocupado           <= 1'b0;
      end else begin
         mem_we            <= (prox == GRAVA);
         wr_loaded         <= (prox == GRAVA);
         disparo_concluido <= (prox == SINALIZA);
         sem_slot          <= (prox == CHEIO);
         ocupado           <= (prox != INICIO) && (prox != ESPERA);
      end
   end

   assign mem_addr  = addr;
   assign wr_x      = lat_x;
   assign wr_y      = lat_y;
   assign wr_opcode = lat_op;
   assign db_estado = estado;

endmodule

// File: doc/uc_dispara_tiro.md
Name: uc_dispara_tiro

Overview:
Control unit plus address counter that spawns a new shot into the shot memory. It takes a fire request carrying the ship position and direction, scans the memory for the first slot with loaded=0, and writes {x, y, opcode, loaded=1} there. It writes to the same memory that the shot-movement unit reads and updates, and it is mutually exclusive with that unit through bloqueio and ocupado.

Parameters:
N_TIROS, 8, number of shot slots in memory
ADDR_W, 3, slot address width (2^ADDR_W >= N_TIROS)
COORD_W, 8, width of the x and y coordinates
COOLDOWN_CICLOS, 16, minimum gap in cycles between accepted shots (used only with UC_DISPARA_TIRO_COOLDOWN_EN)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
disparar  in  1  fire request; one-cycle pulse or level, sampled on each rising edge
bloqueio  in  1  high while the movement unit is active; holds off the start of a new scan
nave_x  in  COORD_W  ship x at request time
nave_y  in  COORD_W  ship y at request time
nave_direcao  in  2  shot opcode (00 x+, 01 x-, 10 y+, 11 y-)
mem_loaded_rd  in  1  loaded bit of the slot at mem_addr; synchronous read with 1-cycle latency
mem_addr  out  ADDR_W  slot address
mem_we  out  1  shot-memory write enable
wr_x  out  COORD_W  x to write
wr_y  out  COORD_W  y to write
wr_opcode  out  2  opcode to write
wr_loaded  out  1  loaded to write
disparo_concluido  out  1  one-cycle pulse: shot written
sem_slot  out  1  one-cycle pulse: all slots loaded, request dropped
ocupado  out  1  high in every state except INICIO and ESPERA
db_estado  out  4  current state code

Behaviour:
- Reset values:
  - state INICIO; pendente=0; mem_addr=0; mem_we=0.
  - Latched x/y/opcode=0, so wr_x=wr_y=wr_opcode=0.
  - wr_loaded=0; disparo_concluido=0; sem_slot=0; ocupado=0.
- Reset mid-operation aborts with no write and clears pendente.
- pendente register:
  - Set on any edge with disparar=1.
  - Cleared on the edge leaving ESPERA toward CAPTURA.
  - Requests arriving while pendente=1 or ocupado=1 merge into one pending request; they do not queue.
  - If disparar=1 on the same edge that clears pendente, pendente stays 1.
- States and codes (all outputs Moore):
  - INICIO(0) -> ESPERA.
  - ESPERA(1) -> CAPTURA if pendente & ~bloqueio; otherwise stay.
  - CAPTURA(2) -> LE. Latches nave_x/nave_y/nave_direcao on the exiting edge and sets mem_addr=0.
  - LE(3) -> VERIFICA. One wait cycle for the read data.
  - VERIFICA(4):
    - ~mem_loaded_rd -> GRAVA.
    - mem_loaded_rd & mem_addr==N_TIROS-1 -> CHEIO.
    - Otherwise -> PROXIMO.
  - PROXIMO(5) -> LE. mem_addr increments on the exiting edge.
  - GRAVA(6) -> SINALIZA. mem_we=1 and wr_loaded=1; mem_addr is held.
  - SINALIZA(7) -> ESPERA. disparo_concluido=1.
  - CHEIO(8) -> ESPERA. sem_slot=1; memory is unchanged.
  - Undefined codes -> INICIO.
- wr_x, wr_y and wr_opcode always reflect the latched registers. The new shot's position equals the ship position, with no offset.
- bloqueio is checked only in ESPERA. It is ignored once a scan has started; the movement unit must wait on ocupado.
- Latency, counting edge 0 as the edge that samples disparar with bloqueio=0:
  - Slot k is the first free slot: GRAVA in the cycle after edge 4+3k; disparo_concluido high in the cycle after edge 5+3k.
  - All slots full: sem_slot high in the cycle after edge 3N_TIROS+1 (edge 25 for N=8).
- mem_addr never exceeds N_TIROS-1, so it does not wrap.

Optional Feature:
- Macro UC_DISPARA_TIRO_COOLDOWN_EN.
- When defined:
  - A counter of width clog2(COOLDOWN_CICLOS+1) loads COOLDOWN_CICLOS on the edge leaving SINALIZA.
  - It decrements by 1 each cycle down to 0.
  - While it is nonzero, disparar is discarded and does not set pendente.
  - CHEIO does not load the counter.
  - Reset clears the counter.
- When undefined: there is no counter, and every disparar sets pendente.

Test Plan:
- Empty memory, nave=(0x40,0x20), dir=10, disparar pulse -> slot 0 written {40,20,10,1}; mem_we at edge 4; disparo_concluido after edge 5.
- Slots 0-2 loaded, disparar -> addresses 0,1,2,3 visited; write to 3; disparo_concluido after edge 14.
- All 8 slots loaded -> sem_slot pulse after edge 25; mem_we never asserted; state returns to ESPERA.
- bloqueio=1 held for 10 cycles, with disparar pulsed at cycle 2 and again at cycle 5 -> exactly one write, and the scan starts 1 cycle after bloqueio falls.
- Reset asserted in PROXIMO -> all outputs return to reset values and no write occurs; a following request writes normally.
- With UC_DISPARA_TIRO_COOLDOWN_EN: two requests 5 cycles apart after a completion are ignored (COOLDOWN_CICLOS=16); a request 17 cycles after SINALIZA is accepted.
